// File: rtl/fmc_i2c_init_sequencer.sv
// FMC424 bring-up sequencer: walks a table of I2C register writes, hands each one to the
// byte-level I2C master, retries NACKs/timeouts with a backoff and reports done or error.
module fmc_i2c_init_sequencer #(
    parameter int NUM_ENTRIES = 4,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_CYC = 1000,
    parameter int TIMEOUT_CYC = 200000,
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    output logic [IW-1:0] tbl_idx,
    input  logic [22:0]   tbl_entry,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [6:0]    cmd_addr,
    output logic [7:0]    cmd_reg,
    output logic [7:0]    cmd_data,
    input  logic          rsp_valid,
    input  logic          rsp_nack,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_idx,
    output logic          err_timeout,
    output logic [2:0]    state_dbg
);

    localparam int BW = $clog2(BACKOFF_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_ENTRIES - 1);
    localparam logic [BW-1:0] BO_LAST     = BW'(BACKOFF_CYC - 1);
    localparam logic [BW-1:0] BO_SAT      = '1;
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT     = '1;
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RSP = 3'd3,
        BACKOFF  = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [3:0]    retry_cnt;
    logic [BW-1:0] bo_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          rsp_ok;
    logic          fail;
    logic          fail_tmo;
    logic          can_retry;
    logic          last_entry;

    // Command handshake: cmd_valid is held with a frozen payload until the cycle where
    // cmd_valid && cmd_ready, which is the single transfer; it drops the cycle after.
    assign cmd_valid  = (state == ISSUE);
    assign state_dbg  = state;

    // Only meaningful in WAIT_RSP; a response in the same cycle as the timeout wins.
    assign rsp_ok     = rsp_valid && !rsp_nack;
    assign fail       = rsp_valid ? rsp_nack : (tmo_cnt == TMO_LAST);
    assign fail_tmo   = !rsp_valid;
    assign can_retry  = (retry_cnt != RETRY_LIMIT);
    assign last_entry = (tbl_idx == LAST_IDX);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_n = FETCH;
            end
            FETCH: state_n = ISSUE;
            ISSUE: begin
                if (cmd_ready) state_n = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_ok) begin
                    state_n = last_entry ? DONE : FETCH;
                end else if (fail) begin
                    state_n = can_retry ? BACKOFF : ERROR;
                end
            end
            BACKOFF: begin
                if (bo_cnt == BO_LAST) state_n = ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tbl_idx     <= '0;
            cmd_addr    <= '0;
            cmd_reg     <= '0;
            cmd_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_idx     <= '0;
            err_timeout <= 1'b0;
            retry_cnt   <= '0;
            bo_cnt      <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        tbl_idx     <= '0;
                        retry_cnt   <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    cmd_addr  <= tbl_entry[22:16];
                    cmd_reg   <= tbl_entry[15:8];
                    cmd_data  <= tbl_entry[7:0];
                    retry_cnt <= '0;
                end
                ISSUE: begin
                    if (cmd_ready) tmo_cnt <= '0;
                end
                WAIT_RSP: begin
                    if (tmo_cnt != TMO_SAT) tmo_cnt <= tmo_cnt + TW'(1);
                    if (rsp_ok) begin
                        if (last_entry) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            tbl_idx <= tbl_idx + IW'(1);
                        end
                    end else if (fail) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            bo_cnt    <= '0;
                        end else begin
                            error       <= 1'b1;
                            busy        <= 1'b0;
                            err_idx     <= tbl_idx;
                            err_timeout <= fail_tmo;
                        end
                    end
                end
                BACKOFF: begin
                    // Payload registers are left alone so the retry resends the same write.
                    if (bo_cnt != BO_SAT) bo_cnt <= bo_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// Directed bench for fmc_i2c_init_sequencer: two instances (3-entry with retries, 2-entry
// without retries) driven through nominal, retry, exhaustion, timeout, backpressure and reset.
`timescale 1ns/1ps
module tb_fmc_i2c_init_sequencer;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_BACKOFF = 3'd4;

    localparam logic [22:0] TBL [4] = '{
        {7'h3E, 8'h02, 8'h01},
        {7'h70, 8'hE6, 8'h10},
        {7'h21, 8'h5A, 8'hC3},
        23'h0
    };

    // Unit 0: NUM_ENTRIES=3, MAX_RETRY=2. Unit 1: NUM_ENTRIES=2, MAX_RETRY=0.
    logic        clk = 1'b0;
    logic        reset;
    logic        start [2];
    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic        rsp_nack [2];
    logic [22:0] tbl_entry [2];
    logic        cmd_valid [2];
    logic [6:0]  cmd_addr [2];
    logic [7:0]  cmd_reg [2];
    logic [7:0]  cmd_data [2];
    logic        busy [2];
    logic        done [2];
    logic        error [2];
    logic        err_timeout [2];
    logic [1:0]  tbl_idx [2];
    logic [1:0]  err_idx [2];
    logic [2:0]  state_dbg [2];
    logic        tbl_idx_b;
    logic        err_idx_b;

    int          acc_cnt [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;
    logic [22:0] exp_q [$];

    always #5 clk = ~clk;

    assign tbl_idx[1]   = {1'b0, tbl_idx_b};
    assign err_idx[1]   = {1'b0, err_idx_b};
    assign tbl_entry[0] = TBL[tbl_idx[0]];
    assign tbl_entry[1] = TBL[tbl_idx[1]];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cmd_valid[u] === 1'b1 && cmd_ready[u] === 1'b1) acc_cnt[u] <= acc_cnt[u] + 1;
        end
    end

    fmc_i2c_init_sequencer #(
        .NUM_ENTRIES(3), .MAX_RETRY(2), .BACKOFF_CYC(5), .TIMEOUT_CYC(50)
    ) dut_a (
        .CLK(clk), .reset(reset), .start(start[0]), .tbl_idx(tbl_idx[0]),
        .tbl_entry(tbl_entry[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr[0]), .cmd_reg(cmd_reg[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_nack(rsp_nack[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .err_idx(err_idx[0]), .err_timeout(err_timeout[0]),
        .state_dbg(state_dbg[0])
    );

    fmc_i2c_init_sequencer #(
        .NUM_ENTRIES(2), .MAX_RETRY(0), .BACKOFF_CYC(5), .TIMEOUT_CYC(50)
    ) dut_b (
        .CLK(clk), .reset(reset), .start(start[1]), .tbl_idx(tbl_idx_b),
        .tbl_entry(tbl_entry[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr[1]), .cmd_reg(cmd_reg[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_nack(rsp_nack[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .err_idx(err_idx_b), .err_timeout(err_timeout[1]),
        .state_dbg(state_dbg[1])
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
    endtask

    task automatic send_rsp(input int u, input int delay, input logic nack);
        repeat (delay) tick();
        rsp_valid[u] = 1'b1;
        rsp_nack[u]  = nack;
        tick();
        rsp_valid[u] = 1'b0;
        rsp_nack[u]  = 1'b0;
    endtask

    task automatic wait_cmd(input int u, input int budget, output logic [22:0] got, output bit seen);
        int n = 0;
        while (cmd_valid[u] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        seen = (cmd_valid[u] === 1'b1);
        got  = {cmd_addr[u], cmd_reg[u], cmd_data[u]};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({busy[u], done[u], error[u], err_timeout[u], cmd_valid[u]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags u%0d: got %b want 00000", u,
                         {busy[u], done[u], error[u], err_timeout[u], cmd_valid[u]});
            end
            checks++;
            if ({cmd_addr[u], cmd_reg[u], cmd_data[u], tbl_idx[u], err_idx[u]} !== 27'h0) begin
                errors++;
                $display("FAIL reset_regs u%0d: got %h want 0", u,
                         {cmd_addr[u], cmd_reg[u], cmd_data[u], tbl_idx[u], err_idx[u]});
            end
            checks++;
            if (state_dbg[u] !== ST_IDLE) begin
                errors++;
                $display("FAIL reset_state u%0d: got %0d want %0d", u, state_dbg[u], ST_IDLE);
            end
        end
    endtask

    task automatic test_nominal();
        logic [22:0] exp;
        int a0 = acc_cnt[1];
        exp_q.push_back(TBL[0]);
        exp_q.push_back(TBL[1]);
        pulse_start(1);
        checks++;
        if ({busy[1], cmd_valid[1], tbl_idx[1], state_dbg[1]} !== {2'b10, 2'd0, ST_FETCH}) begin
            errors++;
            $display("FAIL nominal_cycle1: got %b want %b", {busy[1], cmd_valid[1], tbl_idx[1], state_dbg[1]},
                     {2'b10, 2'd0, ST_FETCH});
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (cmd_valid[1] !== 1'b1 || {cmd_addr[1], cmd_reg[1], cmd_data[1]} !== exp) begin
            errors++;
            $display("FAIL nominal_cmd0: valid %b payload %h want 1 %h", cmd_valid[1],
                     {cmd_addr[1], cmd_reg[1], cmd_data[1]}, exp);
        end
        tick();
        send_rsp(1, 9, 1'b0);
        checks++;
        if ({cmd_valid[1], tbl_idx[1], state_dbg[1]} !== {1'b0, 2'd1, ST_FETCH}) begin
            errors++;
            $display("FAIL nominal_advance: got %b want %b", {cmd_valid[1], tbl_idx[1], state_dbg[1]},
                     {1'b0, 2'd1, ST_FETCH});
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (cmd_valid[1] !== 1'b1 || {cmd_addr[1], cmd_reg[1], cmd_data[1]} !== exp) begin
            errors++;
            $display("FAIL nominal_cmd1: valid %b payload %h want 1 %h", cmd_valid[1],
                     {cmd_addr[1], cmd_reg[1], cmd_data[1]}, exp);
        end
        tick();
        send_rsp(1, 9, 1'b0);
        checks++;
        if ({done[1], error[1], busy[1]} !== 3'b100) begin
            errors++;
            $display("FAIL nominal_done: done/error/busy %b want 100", {done[1], error[1], busy[1]});
        end
        checks++;
        if (acc_cnt[1] - a0 !== 2) begin
            errors++;
            $display("FAIL nominal_count: got %0d commands want 2", acc_cnt[1] - a0);
        end
    endtask

    task automatic test_nack_retry();
        logic [22:0] exp;
        logic [22:0] got;
        bit seen;
        int a0 = acc_cnt[0];
        exp_q.push_back(TBL[0]);
        exp_q.push_back(TBL[0]);
        exp_q.push_back(TBL[1]);
        exp_q.push_back(TBL[2]);
        pulse_start(0);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (cmd_valid[0] !== 1'b1 || {cmd_addr[0], cmd_reg[0], cmd_data[0]} !== exp) begin
            errors++;
            $display("FAIL nack_first: valid %b payload %h want 1 %h", cmd_valid[0],
                     {cmd_addr[0], cmd_reg[0], cmd_data[0]}, exp);
        end
        tick();
        send_rsp(0, 3, 1'b1);
        checks++;
        if ({cmd_valid[0], busy[0], state_dbg[0]} !== {2'b01, ST_BACKOFF}) begin
            errors++;
            $display("FAIL nack_backoff: got %b want %b", {cmd_valid[0], busy[0], state_dbg[0]},
                     {2'b01, ST_BACKOFF});
        end
        repeat (4) tick();
        checks++;
        if (cmd_valid[0] !== 1'b0 || state_dbg[0] !== ST_BACKOFF) begin
            errors++;
            $display("FAIL nack_backoff_len: valid %b state %0d want 0 %0d", cmd_valid[0], state_dbg[0],
                     ST_BACKOFF);
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (cmd_valid[0] !== 1'b1 || {cmd_addr[0], cmd_reg[0], cmd_data[0]} !== exp) begin
            errors++;
            $display("FAIL nack_retry_cmd: valid %b payload %h want 1 %h", cmd_valid[0],
                     {cmd_addr[0], cmd_reg[0], cmd_data[0]}, exp);
        end
        tick();
        send_rsp(0, 3, 1'b0);
        for (int k = 1; k < 3; k++) begin
            wait_cmd(0, 4, got, seen);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL nack_entry%0d: seen %b payload %h want 1 %h", k, seen, got, exp);
            end
            tick();
            send_rsp(0, 3, 1'b0);
        end
        checks++;
        if ({done[0], error[0], busy[0]} !== 3'b100 || acc_cnt[0] - a0 !== 4) begin
            errors++;
            $display("FAIL nack_done: done/error/busy %b cmds %0d want 100 4", {done[0], error[0], busy[0]},
                     acc_cnt[0] - a0);
        end
    endtask

    task automatic test_retry_exhaust();
        logic [22:0] exp;
        logic [22:0] got;
        bit seen;
        int a0 = acc_cnt[0];
        int stray = 0;
        exp_q.push_back(TBL[0]);
        for (int k = 0; k < 3; k++) exp_q.push_back(TBL[1]);
        pulse_start(0);
        for (int k = 0; k < 4; k++) begin
            wait_cmd(0, 10, got, seen);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL exhaust_attempt%0d: seen %b payload %h want 1 %h", k, seen, got, exp);
            end
            tick();
            send_rsp(0, 2, (k != 0));
        end
        checks++;
        if ({error[0], busy[0], done[0], err_timeout[0], err_idx[0]} !== {4'b1000, 2'd1}) begin
            errors++;
            $display("FAIL exhaust_error: error/busy/done/tmo/idx %b want 100001",
                     {error[0], busy[0], done[0], err_timeout[0], err_idx[0]});
        end
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid[0] !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray !== 0 || acc_cnt[0] - a0 !== 4 || tbl_idx[0] !== 2'd1) begin
            errors++;
            $display("FAIL exhaust_quiet: stray %0d cmds %0d idx %0d want 0 4 1", stray, acc_cnt[0] - a0,
                     tbl_idx[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [22:0] exp;
        logic [22:0] got;
        bit seen;
        int a0 = acc_cnt[0];
        int unstable = 0;
        exp_q.push_back(TBL[0]);
        exp_q.push_back(TBL[1]);
        exp_q.push_back(TBL[2]);
        cmd_ready[0] = 1'b0;
        pulse_start(0);
        tick();
        exp = exp_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid[0] !== 1'b1 || {cmd_addr[0], cmd_reg[0], cmd_data[0]} !== exp) unstable++;
            rsp_valid[0] = (i == 5);
            start[0]     = (i == 10);
            tick();
        end
        rsp_valid[0] = 1'b0;
        start[0]     = 1'b0;
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable cycles want 0", unstable);
        end
        checks++;
        if ({state_dbg[0], tbl_idx[0], busy[0], error[0]} !== {ST_ISSUE, 2'd0, 2'b10}) begin
            errors++;
            $display("FAIL bp_hold: got %b want %b", {state_dbg[0], tbl_idx[0], busy[0], error[0]},
                     {ST_ISSUE, 2'd0, 2'b10});
        end
        cmd_ready[0] = 1'b1;
        tick();
        send_rsp(0, 4, 1'b0);
        for (int k = 1; k < 3; k++) begin
            wait_cmd(0, 4, got, seen);
            exp = exp_q.pop_front();
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL bp_entry%0d: seen %b payload %h want 1 %h", k, seen, got, exp);
            end
            tick();
            send_rsp(0, 4, 1'b0);
        end
        checks++;
        if ({done[0], error[0], busy[0]} !== 3'b100 || acc_cnt[0] - a0 !== 3) begin
            errors++;
            $display("FAIL bp_done: done/error/busy %b cmds %0d want 100 3", {done[0], error[0], busy[0]},
                     acc_cnt[0] - a0);
        end
    endtask

    task automatic test_timeout();
        logic [22:0] exp;
        exp_q.push_back(TBL[0]);
        pulse_start(1);
        checks++;
        if ({done[1], busy[1]} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_restart_from_done: done/busy %b want 01", {done[1], busy[1]});
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (cmd_valid[1] !== 1'b1 || {cmd_addr[1], cmd_reg[1], cmd_data[1]} !== exp) begin
            errors++;
            $display("FAIL tmo_cmd: valid %b payload %h want 1 %h", cmd_valid[1],
                     {cmd_addr[1], cmd_reg[1], cmd_data[1]}, exp);
        end
        tick();
        repeat (49) tick();
        checks++;
        if ({error[1], busy[1], state_dbg[1]} !== {2'b01, ST_WAIT}) begin
            errors++;
            $display("FAIL tmo_early: error/busy/state %b want %b", {error[1], busy[1], state_dbg[1]},
                     {2'b01, ST_WAIT});
        end
        tick();
        checks++;
        if ({error[1], err_timeout[1], busy[1], done[1], err_idx[1]} !== {4'b1100, 2'd0}) begin
            errors++;
            $display("FAIL tmo_error: error/tmo/busy/done/idx %b want 110000",
                     {error[1], err_timeout[1], busy[1], done[1], err_idx[1]});
        end
    endtask

    task automatic test_reset_restart();
        logic [22:0] exp;
        logic [22:0] got;
        bit seen;
        exp_q.push_back(TBL[0]);
        pulse_start(1);
        checks++;
        if ({error[1], err_timeout[1], busy[1]} !== 3'b001) begin
            errors++;
            $display("FAIL rr_clear_error: error/tmo/busy %b want 001", {error[1], err_timeout[1], busy[1]});
        end
        tick();
        exp = exp_q.pop_front();
        tick();
        repeat (3) tick();
        checks++;
        if (state_dbg[1] !== ST_WAIT || exp !== TBL[0]) begin
            errors++;
            $display("FAIL rr_in_wait: state %0d want %0d", state_dbg[1], ST_WAIT);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy[1], done[1], error[1], err_timeout[1], cmd_valid[1], tbl_idx[1], err_idx[1],
             cmd_addr[1], cmd_reg[1], cmd_data[1], state_dbg[1]} !== 35'h0) begin
            errors++;
            $display("FAIL rr_async_reset: got %h want 0", {busy[1], done[1], error[1], err_timeout[1],
                     cmd_valid[1], tbl_idx[1], err_idx[1], cmd_addr[1], cmd_reg[1], cmd_data[1], state_dbg[1]});
        end
        tick();
        reset = 1'b0;
        tick();
        for (int run = 0; run < 2; run++) begin
            exp_q.push_back(TBL[0]);
            exp_q.push_back(TBL[1]);
            pulse_start(1);
            checks++;
            if ({busy[1], done[1], tbl_idx[1]} !== 4'b1000) begin
                errors++;
                $display("FAIL rr_start%0d: busy/done/idx %b want 1000", run, {busy[1], done[1], tbl_idx[1]});
            end
            for (int k = 0; k < 2; k++) begin
                wait_cmd(1, 4, got, seen);
                exp = exp_q.pop_front();
                checks++;
                if (!seen || got !== exp) begin
                    errors++;
                    $display("FAIL rr_run%0d_entry%0d: seen %b payload %h want 1 %h", run, k, seen, got, exp);
                end
                tick();
                send_rsp(1, 2, 1'b0);
            end
            checks++;
            if ({done[1], error[1], busy[1]} !== 3'b100) begin
                errors++;
                $display("FAIL rr_done%0d: done/error/busy %b want 100", run, {done[1], error[1], busy[1]});
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u]     = 1'b0;
            cmd_ready[u] = 1'b1;
            rsp_valid[u] = 1'b0;
            rsp_nack[u]  = 1'b0;
        end
        repeat (2) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_reset();
        test_nominal();
        test_nack_retry();
        test_retry_exhaust();
        test_backpressure();
        test_timeout();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
